cgra_exec_scheduler: RTL

- Shares one CGRA routing tile among NUM_REQ requesters.
- Round-robin arbitration picks one requester per job.
- Each job runs three phases: stream CFG_WORDS configuration words into the fabric, enable execution for a requester-supplied cycle count, then pulse done.
- Sits between host-side job sources and the write-on-exec fabric, which it drives through a cfg valid/ready handshake and exec_en.

---
 rtl/cgra_exec_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cgra_exec_scheduler.sv
// Round-robin scheduler that hands one shared CGRA tile to a requester per job: config stream, timed exec, done pulse.
// Optional build macro CGRA_SCHED_PERF_CNT_EN adds perf_exec_cycles / perf_jobs counters.
module cgra_exec_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int CFG_WORDS = 8,
    parameter int CYC_W     = 8,
    localparam int SEL_W    = $clog2(NUM_REQ),
    localparam int IDX_W    = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CYC_W-1:0] req_cycles,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     cfg_valid,
    input  logic                     cfg_ready,
    output logic [SEL_W-1:0]         cfg_sel,
    output logic [IDX_W-1:0]         cfg_idx,
    output logic                     exec_en,
    output logic                     busy
`ifdef CGRA_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]              perf_exec_cycles,
    output logic [15:0]              perf_jobs
`endif
);

    typedef enum logic [1:0] {IDLE, CONFIG, EXEC, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CFG_WORDS - 1);

    state_t           state;
    logic [SEL_W-1:0] rr_ptr;
    logic [CYC_W-1:0] cycles;
    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    logic [SEL_W-1:0] next_ptr;
    logic             owner_req;

    // First set request bit at or above rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = SEL_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign next_ptr  = SEL_W'((int'(win_idx) + 1) % NUM_REQ);
    assign owner_req = |(req & grant);

    // Config handshake: word cfg_idx transfers on a rising edge with cfg_valid && cfg_ready;
    // until then cfg_valid stays high and cfg_idx is held stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            done      <= '0;
            cfg_valid <= 1'b0;
            cfg_sel   <= '0;
            cfg_idx   <= '0;
            exec_en   <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            cycles    <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= CONFIG;
                        grant     <= NUM_REQ'(1) << win_idx;
                        cfg_sel   <= win_idx;
                        cycles    <= req_cycles[int'(win_idx)*CYC_W +: CYC_W];
                        cfg_idx   <= '0;
                        cfg_valid <= 1'b1;
                        busy      <= 1'b1;
                        rr_ptr    <= next_ptr;
                    end
                end
                CONFIG: begin
                    if (!owner_req) begin
                        state     <= IDLE;
                        grant     <= '0;
                        cfg_valid <= 1'b0;
                        cfg_idx   <= '0;
                        busy      <= 1'b0;
                    end else if (cfg_ready) begin
                        if (cfg_idx == LAST_IDX) begin
                            cfg_idx   <= '0;
                            cfg_valid <= 1'b0;
                            if (cycles != '0) begin
                                state   <= EXEC;
                                exec_en <= 1'b1;
                            end else begin
                                state <= DONE;
                                done  <= grant;
                            end
                        end else begin
                            cfg_idx <= cfg_idx + 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (!owner_req) begin
                        state   <= IDLE;
                        grant   <= '0;
                        exec_en <= 1'b0;
                        busy    <= 1'b0;
                    end else if (cycles == CYC_W'(1)) begin
                        state   <= DONE;
                        exec_en <= 1'b0;
                        done    <= grant;
                    end else begin
                        cycles <= cycles - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CGRA_SCHED_PERF_CNT_EN
    // Exec cycles of aborted jobs still count; only completed jobs bump perf_jobs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_exec_cycles <= '0;
            perf_jobs        <= '0;
        end else begin
            if (exec_en && (perf_exec_cycles != 32'hFFFF_FFFF))
                perf_exec_cycles <= perf_exec_cycles + 32'd1;
            if (|done)
                perf_jobs <= perf_jobs + 16'd1;
        end
    end
`endif

endmodule
